// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: definitions shared by the round-robin grant arbiter and its picker.
//   N_REQ    : number of requesters (fixed at 4)
//   IDX_W    : width of a requester index
//   state_e  : arbiter FSM states
//   onehot4  : converts a requester index into its one-hot grant code
package rr_arb4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotating-priority picker.
//   mask_i  [3:0] : candidate requesters
//   ptr_i   [1:0] : highest-priority position; search runs ptr, ptr+1, ... mod 4
//   found_o       : at least one candidate is set
//   idx_o   [1:0] : first set candidate in cyclic order from ptr_i
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Rotate the mask so that bit 0 is the requester at ptr; a plain
  // lowest-bit search on the rotated view then gives cyclic priority.
  logic [N_REQ-1:0] rot_mask;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot_mask[gi] = mask[ptr + IDX_W'(gi)];
  end

  logic [IDX_W-1:0] offset;

  always_comb begin
    offset = '0;
    // Descending scan so the smallest set offset is the one that sticks.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_mask[i]) begin
        offset = IDX_W'(i);
      end
    end
  end

  assign found = |rot_mask;
  assign idx   = ptr + offset;

endmodule

// File: rtl/rr_arb4_grant.sv
// rr_arb4_grant: four-requester round-robin arbiter with hold-time limit.
// Produces a registered one-hot grant that feeds a 4-to-2 encoder.
//   MAX_HOLD      : max consecutive grant cycles while others wait (1..255)
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   req     [3:0] : request lines
//   gnt     [3:0] : registered one-hot grant, or zero
//   gnt_vld       : registered, equals |gnt (encoder enable)
//   gnt_new       : registered one-cycle pulse on the first cycle of each grant
module rr_arb4_grant
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic             gnt_new
);

  localparam int           CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] own_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             vld_q;
  logic             new_q;

  // Picker inputs. In GRANT the search always starts just past the owner,
  // which is exactly the pointer value a release/preempt would install;
  // in the hold case the pick result is simply ignored.
  logic [N_REQ-1:0] pick_mask_d;
  logic [IDX_W-1:0] pick_ptr_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    pick_mask_d = req;
    pick_ptr_d  = ptr_q;
    if (state_q == GRANT) begin
      pick_mask_d = req & ~onehot4(own_q);
      pick_ptr_d  = own_q + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .mask  (pick_mask_d),
    .ptr   (pick_ptr_d),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          new_q <= 1'b0;
          if (pick_found) begin
            gnt_q   <= onehot4(pick_idx);
            vld_q   <= 1'b1;
            new_q   <= 1'b1;
            own_q   <= pick_idx;
            cnt_q   <= CNT_W'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req[own_q] && ((cnt_q < MAX_C) || !pick_found)) begin
            // Hold: counter saturates so an uncontended owner keeps the grant.
            new_q <= 1'b0;
            if (cnt_q < MAX_C) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // Release or preempt: both rotate the pointer past the owner.
            ptr_q <= own_q + 2'd1;
            if (pick_found) begin
              gnt_q <= onehot4(pick_idx);
              vld_q <= 1'b1;
              new_q <= 1'b1;
              own_q <= pick_idx;
              cnt_q <= CNT_W'(1);
            end else begin
              gnt_q   <= '0;
              vld_q   <= 1'b0;
              new_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_new = new_q;

endmodule

// File: tb/tb_rr_arb4_grant.sv
module tb_rr_arb4_grant;

  typedef struct packed {
    logic [3:0] g;
    logic       v;
    logic       n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b, new_a, new_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Two instances so both the short-hold rotation and long-hold saturation
  // behaviours are exercised by the same stimulus stream.
  rr_arb4_grant #(.MAX_HOLD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_a), .gnt_vld(vld_a), .gnt_new(new_a)
  );
  rr_arb4_grant #(.MAX_HOLD(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_b), .gnt_vld(vld_b), .gnt_new(new_b)
  );

  // Reference model: owner as an integer (-1 = none), priority start, hold length.
  int m_hold_max [2] = '{2, 8};
  int m_owner    [2] = '{-1, -1};
  int m_ptr      [2] = '{0, 0};
  int m_held     [2] = '{0, 0};
  exp_t sb_a[$];
  exp_t sb_b[$];

  function automatic int first_from(input logic [3:0] cand, input int start);
    for (int k = 0; k < 4; k++) begin
      if (cand[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    exp_t e;
    int   nxt;
    logic [3:0] others;
    logic fresh;
    fresh = 1'b0;
    if (!rst_n) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
    end else if (m_owner[d] < 0) begin
      nxt = first_from(req, m_ptr[d]);
      if (nxt >= 0) begin
        m_owner[d] = nxt;
        m_held[d]  = 1;
        fresh      = 1'b1;
      end
    end else begin
      others = req;
      others[m_owner[d]] = 1'b0;
      if (req[m_owner[d]] && (m_held[d] < m_hold_max[d] || others == 4'b0)) begin
        if (m_held[d] < m_hold_max[d]) m_held[d]++;
      end else begin
        m_ptr[d] = (m_owner[d] + 1) % 4;
        nxt = first_from(others, m_ptr[d]);
        m_owner[d] = nxt;
        m_held[d]  = (nxt >= 0) ? 1 : 0;
        fresh      = (nxt >= 0);
      end
    end
    e.g = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
    e.v = (m_owner[d] >= 0);
    e.n = fresh;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // Monitor: pops one expectation per instance every cycle, away from the edge.
  task automatic check_one(input string name, input exp_t e,
                           input logic [3:0] g, input logic v, input logic n);
    checks++;
    if ({g, v, n} !== {e.g, e.v, e.n}) begin
      errors++;
      $display("FAIL %s cyc=%0d req=%b got gnt=%b vld=%b new=%b want gnt=%b vld=%b new=%b",
               name, cyc, req, g, v, n, e.g, e.v, e.n);
    end
    checks++;
    if ((g & (g - 4'd1)) != 4'b0 || v !== (|g)) begin
      errors++;
      $display("FAIL %s_onehot cyc=%0d got gnt=%b vld=%b want onehot-or-zero with vld=|gnt",
               name, cyc, g, v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        check_one("hold2", e, gnt_a, vld_a, new_a);
        $display("cyc=%0d rst_n=%b req=%b | A gnt=%b vld=%b new=%b | B gnt=%b vld=%b new=%b",
                 cyc, rst_n, req, gnt_a, vld_a, new_a, gnt_b, vld_b, new_b);
      end
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        check_one("hold8", e, gnt_b, vld_b, new_b);
      end
    end
  end

  task automatic drive(input logic r, input logic [3:0] q, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst_n = r;
      req   = q;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    // Reset then idle.
    drive(1'b0, 4'b0000, 2);
    drive(1'b1, 4'b0000, 5);
    // Single request on line 2, then release (pointer moves to 3).
    drive(1'b1, 4'b0100, 3);
    drive(1'b1, 4'b0000, 2);
    // Full contention starting at pointer 3.
    drive(1'b1, 4'b1111, 10);
    drive(1'b0, 4'b0000, 1);
    // Fair rotation from a fresh reset.
    drive(1'b1, 4'b1111, 10);
    drive(1'b0, 4'b0000, 1);
    // Release handoff: owner 0 drops while 1 and 3 request.
    drive(1'b1, 4'b0001, 1);
    drive(1'b1, 4'b1010, 3);
    drive(1'b1, 4'b0000, 2);
    // No preempt without contention.
    drive(1'b1, 4'b0001, 20);
    drive(1'b1, 4'b0000, 1);
    // Mid-grant reset with request held.
    drive(1'b1, 4'b0010, 2);
    drive(1'b0, 4'b0010, 1);
    drive(1'b1, 4'b0010, 3);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)), 1);
    end
    drive(1'b1, 4'b0000, 3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_a.size() > 1 || sb_b.size() > 1) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d want at most 1", sb_a.size(), sb_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
